// File: rtl/iop_dispatch.sv
// rtl/iop_dispatch.sv - in-order dispatch queue between decode and two reservation stations
//
// Purpose:
//   Buffers decoded internal operations {iop, init, pc, k16} in a DEPTH-entry
//   FIFO and hands the head entry to whichever station raises id_feed,
//   alternating round-robin when both stations request in the same cycle.
//
// Ports:
//   clk, a_rst          clock; asynchronous active-high reset
//   flush               synchronous queue clear (suppresses push and ack)
//   dec_valid/dec_ready decoder handshake; dec_ready = ~full & ~flush
//   dec_iop/iop_init/pc/k16  entry fields from the decoder
//   st_feed[1:0]        per-station work request (id_feed)
//   st_ack[1:0]         per-station grant (id_ack), one-hot or zero
//   st_iop/iop_init/pc/k16   head entry, zero while the queue is empty
//   count               number of occupied entries

module iop_dispatch #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_iop,
  input  logic [2:0]       dec_iop_init,
  input  logic [15:0]      dec_pc,
  input  logic [15:0]      dec_k16,
  input  logic [1:0]       st_feed,
  output logic [1:0]       st_ack,
  output logic [31:0]      st_iop,
  output logic [2:0]       st_iop_init,
  output logic [15:0]      st_pc,
  output logic [15:0]      st_k16,
  output logic [PTR_W:0]   count
);

  localparam int ENTRY_W = 67;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rr_q, rr_d;

  logic             full;
  logic             nonempty;
  logic             push;
  logic             pop;
  logic [1:0]       req;
  logic [ENTRY_W-1:0] head;

  assign full      = (count_q == FULL_CNT);
  assign nonempty  = (count_q != '0);
  // Ready is deliberately independent of a same-cycle pop so the decoder
  // never sees a combinational path from the stations.
  assign dec_ready = ~full & ~flush;
  assign push      = dec_valid & dec_ready;
  assign req       = st_feed & {2{nonempty}} & {2{~flush}};
  assign pop       = |st_ack;
  assign count     = count_q;

  // Grant: a lone requester always wins; on contention rr names the winner.
  always_comb begin
    st_ack = 2'b00;
    unique case (req)
      2'b01:   st_ack = 2'b01;
      2'b10:   st_ack = 2'b10;
      2'b11:   st_ack = rr_q ? 2'b10 : 2'b01;
      default: st_ack = 2'b00;
    endcase
  end

  // No bypass: an empty queue shows zeros even while a push is in flight.
  assign head        = nonempty ? mem_q[rd_ptr_q] : '0;
  assign st_iop      = head[66:35];
  assign st_iop_init = head[34:32];
  assign st_pc       = head[31:16];
  assign st_k16      = head[15:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        // rr points at the loser: station 0 winning hands priority to 1.
        rr_d     = st_ack[0];
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
    end
  end

  // Entry storage is never cleared; count gates visibility of stale data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {dec_iop, dec_iop_init, dec_pc, dec_k16};
    end
  end

endmodule

// File: tb/tb_iop_dispatch.sv
// tb/tb_iop_dispatch.sv - self-checking bench for iop_dispatch with a queue-based reference model

module tb_iop_dispatch;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        a_rst = 1'b1;
  logic        flush = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [31:0] dec_iop = '0;
  logic [2:0]  dec_iop_init = '0;
  logic [15:0] dec_pc = '0;
  logic [15:0] dec_k16 = '0;
  logic [1:0]  st_feed = '0;
  logic [1:0]  st_ack;
  logic [31:0] st_iop;
  logic [2:0]  st_iop_init;
  logic [15:0] st_pc;
  logic [15:0] st_k16;
  logic [PTR_W:0] count;

  iop_dispatch #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .a_rst(a_rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_iop(dec_iop), .dec_iop_init(dec_iop_init), .dec_pc(dec_pc), .dec_k16(dec_k16),
    .st_feed(st_feed), .st_ack(st_ack),
    .st_iop(st_iop), .st_iop_init(st_iop_init), .st_pc(st_pc), .st_k16(st_k16),
    .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of entries plus the "who goes next on contention" bit.
  logic [66:0] mq[$];
  logic        m_rr;
  logic [1:0]  m_ack;
  logic        m_ready;
  logic        m_dv;
  logic        m_flush;
  logic [66:0] m_entry;

  logic [72:0] obs;
  logic [72:0] expv;

  function automatic logic [66:0] rand_entry(input logic [15:0] pc);
    logic [31:0] iop;
    logic [2:0]  ini;
    logic [15:0] k;
    iop = $urandom;
    ini = 3'($urandom_range(7));
    k   = 16'($urandom);
    return {iop, ini, pc, k};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rr = 1'b0;
  endtask

  // Drive one cycle's inputs (called just after a rising edge), predict the
  // combinational outputs from the model and sample the DUT on the falling edge.
  task automatic drive_sample(input logic dv, input logic [1:0] feed, input logic fl,
                              input logic [66:0] e);
    logic [1:0]  req;
    logic [66:0] head;
    dec_valid = dv;
    st_feed   = feed;
    flush     = fl;
    {dec_iop, dec_iop_init, dec_pc, dec_k16} = e;
    m_dv    = dv;
    m_flush = fl;
    m_entry = e;
    m_ready = (mq.size() < DEPTH) && !fl;
    req     = (fl || mq.size() == 0) ? 2'b00 : feed;
    if (req == 2'b11)      m_ack = m_rr ? 2'b10 : 2'b01;
    else                   m_ack = req;
    head = (mq.size() != 0) ? mq[0] : '0;
    expv = {m_ack, m_ready, 3'(mq.size()), head};
    @(negedge clk);
    obs = {st_ack, dec_ready, count, st_iop, st_iop_init, st_pc, st_k16};
  endtask

  task automatic clock_commit();
    @(posedge clk);
    if (m_flush) begin
      mq.delete();
    end else begin
      if (m_ack != 2'b00) begin
        void'(mq.pop_front());
        m_rr = (m_ack == 2'b01);
      end
      if (m_dv && m_ready) mq.push_back(m_entry);
    end
    #1;
  endtask

  task automatic do_reset();
    a_rst = 1'b1;
    dec_valid = 1'b0; st_feed = 2'b00; flush = 1'b0;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({st_ack, dec_ready, count, st_iop, st_iop_init, st_pc, st_k16} !== {2'b00, 1'b1, 3'd0, 67'd0}) begin
      errors++;
      $display("FAIL reset_state got ack=%b rdy=%b cnt=%0d iop=%h want ack=00 rdy=1 cnt=0 data=0",
               st_ack, dec_ready, count, st_iop);
    end
  endtask

  task automatic test_basic_latency();
    logic [66:0] e;
    do_reset();
    e = {32'h0000_1234, 3'b110, 16'h0100, 16'hBEEF};
    drive_sample(1'b1, 2'b01, 1'b0, e);
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL basic_push_cycle got %h want %h", obs, expv);
    end
    clock_commit();
    drive_sample(1'b0, 2'b01, 1'b0, '0);
    checks++;
    if (st_ack !== 2'b01 || st_iop !== 32'h0000_1234 || st_pc !== 16'h0100 ||
        st_k16 !== 16'hBEEF || st_iop_init !== 3'b110) begin
      errors++;
      $display("FAIL basic_ack got ack=%b iop=%h pc=%h want ack=01 iop=00001234 pc=0100", st_ack, st_iop, st_pc);
    end
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL basic_model got %h want %h", obs, expv);
    end
    clock_commit();
    checks++;
    if ({count, st_iop, st_iop_init, st_pc, st_k16} !== 70'd0) begin
      errors++; $display("FAIL basic_drained got cnt=%0d iop=%h pc=%h want 0", count, st_iop, st_pc);
    end
    st_feed = 2'b00;
  endtask

  task automatic test_fill_wrap();
    logic [15:0] popped[$];
    int idx;
    int cyc;
    logic acc;
    do_reset();
    idx = 0;
    cyc = 0;
    while (cyc < 40 && !(idx == 6 && mq.size() == 0)) begin
      drive_sample(idx < 6, (cyc < 6) ? 2'b00 : 2'b10, 1'b0, rand_entry(16'(idx)));
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL fill_cycle%0d got %h want %h", cyc, obs, expv);
      end
      if (cyc == 5) begin
        checks++;
        if (count !== 3'd4 || dec_ready !== 1'b0) begin
          errors++; $display("FAIL fill_full got cnt=%0d rdy=%b want cnt=4 rdy=0", count, dec_ready);
        end
      end
      if (st_ack != 2'b00) popped.push_back(st_pc);
      acc = m_dv && m_ready;
      clock_commit();
      if (acc) idx++;
      cyc++;
    end
    checks++;
    if (popped.size() != 6) begin
      errors++; $display("FAIL wrap_pop_count got %0d want 6", popped.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (popped[i] !== 16'(i)) begin
          errors++; $display("FAIL wrap_order%0d got pc=%0d want %0d", i, popped[i], i);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want [4];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_sample(1'b1, 2'b00, 1'b0, rand_entry(16'(16'h40 + i)));
      clock_commit();
    end
    for (int i = 0; i < 4; i++) begin
      drive_sample(1'b0, 2'b11, 1'b0, '0);
      checks++;
      if (st_ack !== want[i] || st_pc !== 16'(16'h40 + i)) begin
        errors++; $display("FAIL rr_step%0d got ack=%b pc=%h want ack=%b pc=%h", i, st_ack, st_pc, want[i], 16'(16'h40 + i));
      end
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL rr_model%0d got %h want %h", i, obs, expv);
      end
      clock_commit();
    end
  endtask

  task automatic test_starvation();
    logic [1:0] want [3];
    logic [1:0] feed [3];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    feed[0] = 2'b01; feed[1] = 2'b11; feed[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      drive_sample(1'b1, 2'b00, 1'b0, rand_entry(16'(16'h80 + i)));
      clock_commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive_sample(1'b0, feed[i], 1'b0, '0);
      checks++;
      if (st_ack !== want[i] || !$onehot0(st_ack) || st_pc !== 16'(16'h80 + i)) begin
        errors++; $display("FAIL starve_step%0d got ack=%b pc=%h want ack=%b", i, st_ack, st_pc, want[i]);
      end
      clock_commit();
    end
  endtask

  task automatic test_flush();
    logic [66:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_sample(1'b1, 2'b00, 1'b0, rand_entry(16'(16'hC0 + i)));
      clock_commit();
    end
    drive_sample(1'b1, 2'b11, 1'b1, rand_entry(16'hDEAD));
    checks++;
    if (st_ack !== 2'b00 || dec_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle got ack=%b rdy=%b want ack=00 rdy=0", st_ack, dec_ready);
    end
    clock_commit();
    flush = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("FAIL flush_count got %0d want 0", count);
    end
    e = rand_entry(16'h0777);
    drive_sample(1'b1, 2'b00, 1'b0, e);
    clock_commit();
    drive_sample(1'b0, 2'b00, 1'b0, '0);
    checks++;
    if (count !== 3'd1 || {st_iop, st_iop_init, st_pc, st_k16} !== e) begin
      errors++; $display("FAIL flush_next_push got cnt=%0d pc=%h want cnt=1 pc=0777", count, st_pc);
    end
    clock_commit();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive_sample(($urandom_range(3) != 0), 2'($urandom), ($urandom_range(15) == 0),
                   rand_entry(16'($urandom)));
      checks++;
      if (obs !== expv || !$onehot0(st_ack)) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle%0d got %h want %h", i, obs, expv);
        bad++;
      end
      clock_commit();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_sample(1'b1, 2'b00, 1'b0, rand_entry(16'(16'hE0 + i)));
      clock_commit();
    end
    drive_sample(1'b0, 2'b11, 1'b0, '0);
    #2;
    a_rst = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || st_ack !== 2'b00 || st_iop !== 32'd0 || dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got cnt=%0d ack=%b iop=%h rdy=%b want cnt=0 ack=00 iop=0 rdy=1",
               count, st_ack, st_iop, dec_ready);
    end
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    st_feed = 2'b00;
    model_reset();
    drive_sample(1'b0, 2'b11, 1'b0, '0);
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL async_after got %h want %h", obs, expv);
    end
    clock_commit();
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_fill_wrap();
    test_round_robin();
    test_starvation();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
